// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU
// load/store stage (c_*) and the IO/DMA engine (i_*).
// - One access per cycle, granted combinationally and issued the same cycle.
// - The single in-flight read is tagged so its data returns to the issuer.
// - A requester holding lock keeps exclusive ownership across accesses.
// Optional feature: define DMEM_ARB_AGING_EN to promote IO after
// STARVE_MAX consecutive denied cycles in IDLE.
module dmem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // CPU port
    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_lock,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    // IO port
    input  logic              i_req,
    input  logic              i_we,
    input  logic              i_lock,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_OWN_C, ST_OWN_I} state_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_C, TAG_I} tag_e;

    state_e state_q, state_d;
    tag_e   rd_tag_q, rd_tag_d;
    logic   c_win, i_win;
    logic   io_prio;

`ifdef DMEM_ARB_AGING_EN
    localparam int AGE_W = $clog2(STARVE_MAX + 1);

    logic [AGE_W-1:0] age_q, age_d;

    // IO is promoted once it has been passed over STARVE_MAX times in IDLE.
    assign io_prio = (state_q == ST_IDLE) && (age_q == AGE_W'(STARVE_MAX));

    // Starvation counter: clears on IO service or IO idle, counts IDLE denials.
    always_comb begin
        age_d = age_q;
        if (i_gnt || !i_req) begin
            age_d = '0;
        end else if ((state_q == ST_IDLE) && (age_q != AGE_W'(STARVE_MAX))) begin
            age_d = age_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    // Fixed CPU-over-IO priority; STARVE_MAX is never negative, so this is 0.
    assign io_prio = (STARVE_MAX < 0);
`endif

    // Raw grant decision from ownership state and priority.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        c_win = 1'b0;
        i_win = 1'b0;
        unique case (state_q)
            ST_OWN_C: c_win = c_req;
            ST_OWN_I: i_win = i_req;
            default: begin
                if (io_prio && i_req) begin
                    i_win = 1'b1;
                end else begin
                    c_win = c_req;
                    i_win = i_req && !c_req;
                end
            end
        endcase
    end

    // Grants are forced low while reset is asserted, even if req is high.
    assign c_gnt = c_win && rst_n;
    assign i_gnt = i_win && rst_n;

    // Lock ownership: enter on a locked grant, leave on any cycle without lock.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (c_gnt && c_lock) begin
                    state_d = ST_OWN_C;
                end else if (i_gnt && i_lock) begin
                    state_d = ST_OWN_I;
                end
            end
            ST_OWN_C: if (!c_lock) state_d = ST_IDLE;
            ST_OWN_I: if (!i_lock) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Memory drive muxed from the granted port; read tag for the return path.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_tag_d  = TAG_NONE;
        if (c_gnt) begin
            mem_en    = !c_we;
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            if (!c_we) rd_tag_d = TAG_C;
        end else if (i_gnt) begin
            mem_en    = !i_we;
            mem_we    = i_we;
            mem_addr  = i_addr;
            mem_wdata = i_wdata;
            if (!i_we) rd_tag_d = TAG_I;
        end
    end

    // State and read-tag registers; reset drops any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_tag_q <= TAG_NONE;
        end else begin
            state_q  <= state_d;
            rd_tag_q <= rd_tag_d;
        end
    end

    // Registered memory data is steered to the port that issued the read.
    assign c_rvalid = (rd_tag_q == TAG_C);
    assign i_rvalid = (rd_tag_q == TAG_I);
    assign c_rdata  = c_rvalid ? mem_rdata : '0;
    assign i_rdata  = i_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed steps followed by a randomized phase, checked
// against a transaction-level reference model (owner, pending read, aging
// count, reference memory image). Build with DMEM_ARB_AGING_EN to check aging.
module tb_dmem_arbiter;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << ADDR_W;

`ifdef DMEM_ARB_AGING_EN
    localparam bit AGING_ON = 1'b1;
`else
    localparam bit AGING_ON = 1'b0;
`endif

    localparam int OWN_NONE = 0;
    localparam int OWN_CPU  = 1;
    localparam int OWN_IO   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              c_req = 1'b0, c_we = 1'b0, c_lock = 1'b0;
    logic [ADDR_W-1:0] c_addr = '0;
    logic [DATA_W-1:0] c_wdata = '0;
    logic              i_req = 1'b0, i_we = 1'b0, i_lock = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [DATA_W-1:0] i_wdata = '0;
    logic              c_gnt, c_rvalid, i_gnt, i_rvalid;
    logic [DATA_W-1:0] c_rdata, i_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                m_own = OWN_NONE;
    int                m_age = 0;
    int                m_pend = OWN_NONE;
    logic [DATA_W-1:0] m_pend_data = '0;
    logic              m_last_gc = 1'b0, m_last_gi = 1'b0;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .i_req(i_req), .i_we(i_we), .i_lock(i_lock), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input int a);
        return (32'(a) * 32'h9E37_79B9) ^ 32'hC3A5_0F1E;
    endfunction

    // Single-port memory behind the arbiter: write at the edge, registered read.
    logic [DATA_W-1:0] mem_arr [DEPTH];
    initial begin
        for (int k = 0; k < DEPTH; k++) mem_arr[k] = init_word(k);
        forever begin
            @(posedge clk);
            if (mem_we) mem_arr[mem_addr] = mem_wdata;
            if (mem_en) mem_rdata <= mem_arr[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive_c(input logic req, input logic we, input logic lock,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        c_req = req; c_we = we; c_lock = lock; c_addr = addr; c_wdata = wd;
    endtask

    task automatic drive_i(input logic req, input logic we, input logic lock,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        i_req = req; i_we = we; i_lock = lock; i_addr = addr; i_wdata = wd;
    endtask

    // One cycle: compare all outputs against the model, advance the model,
    // then move to the next falling edge where new inputs are driven.
    task automatic step();
        logic              gc, gi, gnt_we, e_en, e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        int                new_pend;
        #1;
        if (!rst_n) begin
            m_own = OWN_NONE; m_age = 0; m_pend = OWN_NONE;
        end
        gc = 1'b0; gi = 1'b0;
        if (rst_n) begin
            if (m_own == OWN_CPU) gc = c_req;
            else if (m_own == OWN_IO) gi = i_req;
            else if (AGING_ON && m_age >= STARVE_MAX && i_req) gi = 1'b1;
            else begin
                gc = c_req;
                gi = i_req && !c_req;
            end
        end
        gnt_we = gc ? c_we : i_we;
        e_en   = (gc || gi) && !gnt_we;
        e_we   = (gc || gi) && gnt_we;
        e_addr = gc ? c_addr : (gi ? i_addr : '0);
        e_wd   = gc ? c_wdata : (gi ? i_wdata : '0);

        check("c_gnt", 32'(c_gnt), 32'(gc));
        check("i_gnt", 32'(i_gnt), 32'(gi));
        check("mem_en", 32'(mem_en), 32'(e_en));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_wdata", mem_wdata, e_wd);
        check("c_rvalid", 32'(c_rvalid), 32'(m_pend == OWN_CPU));
        check("i_rvalid", 32'(i_rvalid), 32'(m_pend == OWN_IO));
        check("c_rdata", c_rdata, (m_pend == OWN_CPU) ? m_pend_data : 32'h0);
        check("i_rdata", i_rdata, (m_pend == OWN_IO) ? m_pend_data : 32'h0);

        if (rst_n) begin
            new_pend = OWN_NONE;
            if (gc || gi) begin
                if (gnt_we) ref_mem[e_addr] = e_wd;
                else begin
                    new_pend    = gc ? OWN_CPU : OWN_IO;
                    m_pend_data = ref_mem[e_addr];
                end
            end
            m_pend = new_pend;
            if (gi || !i_req) m_age = 0;
            else if (m_own == OWN_NONE && m_age < STARVE_MAX) m_age++;
            if (m_own == OWN_NONE) begin
                if (gc && c_lock) m_own = OWN_CPU;
                else if (gi && i_lock) m_own = OWN_IO;
            end else if (m_own == OWN_CPU && !c_lock) m_own = OWN_NONE;
            else if (m_own == OWN_IO && !i_lock) m_own = OWN_NONE;
        end
        m_last_gc = gc;
        m_last_gi = gi;
        @(negedge clk);
    endtask

    initial begin
        logic c_busy, i_busy;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = init_word(k);

        // reset with both requests high: every output must stay 0
        drive_c(1'b1, 1'b0, 1'b0, 14'h0005, '0);
        drive_i(1'b1, 1'b1, 1'b0, 14'h0006, 32'h1234_5678);
        step();
        drive_c(1'b0, 1'b0, 1'b0, '0, '0);
        drive_i(1'b0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        step();

        // CPU write then read of the same word
        drive_c(1'b1, 1'b1, 1'b0, 14'h0010, 32'hDEAD_BEEF);
        #1 check("tp1_wr_gnt", 32'(c_gnt), 32'd1);
        step();
        drive_c(1'b1, 1'b0, 1'b0, 14'h0010, '0);
        #1 check("tp1_rd_gnt", 32'(c_gnt), 32'd1);
        step();
        drive_c(1'b0, 1'b0, 1'b0, '0, '0);
        #1 check("tp1_rvalid", 32'(c_rvalid), 32'd1);
        check("tp1_rdata", c_rdata, 32'hDEAD_BEEF);
        check("tp1_i_rvalid", 32'(i_rvalid), 32'd0);
        step();

        // contention: CPU wins three cycles, IO granted once CPU drops
        drive_i(1'b1, 1'b0, 1'b0, 14'h0002, '0);
        for (int k = 0; k < 3; k++) begin
            drive_c(1'b1, 1'b0, 1'b0, 14'h0001, '0);
            #1 check("tp2_i_denied", 32'(i_gnt), 32'd0);
            step();
        end
        drive_c(1'b0, 1'b0, 1'b0, '0, '0);
        #1 check("tp2_i_gnt", 32'(i_gnt), 32'd1);
        step();
        drive_i(1'b0, 1'b0, 1'b0, '0, '0);
        #1 check("tp2_i_rdata", i_rdata, init_word(2));
        step();

        // CPU lock sequence blocks IO until after the unlocking write
        drive_i(1'b1, 1'b1, 1'b0, 14'h0030, 32'hA5A5_0001);
        drive_c(1'b1, 1'b0, 1'b1, 14'h0020, '0);
        step();
        drive_c(1'b0, 1'b0, 1'b1, '0, '0);
        #1 check("tp3_locked0", 32'(i_gnt), 32'd0);
        step();
        #1 check("tp3_locked1", 32'(i_gnt), 32'd0);
        step();
        drive_c(1'b1, 1'b1, 1'b0, 14'h0020, 32'h0BAD_F00D);
        #1 check("tp3_unlock_wr", 32'(i_gnt), 32'd0);
        step();
        drive_c(1'b0, 1'b0, 1'b0, '0, '0);
        #1 check("tp3_i_after", 32'(i_gnt), 32'd1);
        step();
        drive_i(1'b0, 1'b0, 1'b0, '0, '0);

        // interleaved reads C, I, C
        drive_c(1'b1, 1'b0, 1'b0, 14'h0100, '0);
        step();
        drive_c(1'b0, 1'b0, 1'b0, '0, '0);
        drive_i(1'b1, 1'b0, 1'b0, 14'h0200, '0);
        #1 check("tp4_c_rdata", c_rdata, init_word(14'h0100));
        step();
        drive_i(1'b0, 1'b0, 1'b0, '0, '0);
        drive_c(1'b1, 1'b0, 1'b0, 14'h0300, '0);
        #1 check("tp4_i_rdata", i_rdata, init_word(14'h0200));
        step();
        drive_c(1'b0, 1'b0, 1'b0, '0, '0);
        step();

        // reset right after a granted CPU read: the read never returns
        drive_c(1'b1, 1'b0, 1'b0, 14'h0040, '0);
        #1 check("tp5_rd_gnt", 32'(c_gnt), 32'd1);
        rst_n = 1'b0;
        step();
        drive_c(1'b0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        #1 check("tp5_no_rvalid", 32'(c_rvalid), 32'd0);
        step();

        // continuous contention: IO only via aging, every 5th cycle
        drive_c(1'b1, 1'b0, 1'b0, 14'h0001, '0);
        drive_i(1'b1, 1'b0, 1'b0, 14'h0002, '0);
        for (int k = 0; k < 12; k++) begin
`ifdef DMEM_ARB_AGING_EN
            #1 check("tp6_aging", 32'(i_gnt), 32'((k % 5) == 4));
`endif
            step();
        end
        drive_c(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        drive_i(1'b0, 1'b0, 1'b0, '0, '0);
        step();

        // randomized traffic under the hold-until-grant handshake
        c_busy = 1'b0;
        i_busy = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!c_busy)
                drive_c($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 7) == 0, ADDR_W'($urandom_range(0, 15)), $urandom);
            if (!i_busy)
                drive_i($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 7) == 0, ADDR_W'($urandom_range(0, 15)), $urandom);
            step();
            c_busy = c_req && !m_last_gc;
            i_busy = i_req && !m_last_gi;
        end
        drive_c(1'b0, 1'b0, 1'b0, '0, '0);
        drive_i(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
